// File: rtl/ahb_wait_ram_if.sv
// AHB-Lite bus bundle between a bus master and the wait-state RAM subordinate.
// Clock and reset are kept outside as plain ports.
interface ahb_wait_ram_if #(
  parameter int AHBW = 64
);
  logic              HSELRam;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic              HREADY;
  logic [AHBW-1:0]   HWDATA;
  logic [AHBW/8-1:0] HWSTRB;
  logic              HREADOUT;
  logic              HRESP;
  logic [AHBW-1:0]   HRDATA;

  modport master (
    output HSELRam, HADDR, HTRANS, HWRITE, HREADY, HWDATA, HWSTRB,
    input  HREADOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSELRam, HADDR, HTRANS, HWRITE, HREADY, HWDATA, HWSTRB,
    output HREADOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_wait_ram.sv
// AHB-Lite word-addressed RAM that inserts RAM_LATENCY wait states per NONSEQ beat;
// SEQ beats skip the wait when BURST_EN is set. Always responds OKAY.
module ahb_wait_ram #(
  parameter int AHBW        = 64,
  parameter int DEPTH       = 1024,
  parameter int RAM_LATENCY = 0,
  parameter int BURST_EN    = 1
) (
  input logic           HCLK,
  input logic           HRESETn,
  ahb_wait_ram_if.slave bus
);

  localparam int BYTES = AHBW / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((RAM_LATENCY > 0) ? RAM_LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic [AHBW-1:0] mem_q [DEPTH];

  logic accept;
  logic fast;

  // A new address phase can only land while the data phase is not stalled.
  assign accept = bus.HSELRam & bus.HREADY & bus.HTRANS[1] & (state_q != S_WAIT);
  assign fast   = (bus.HTRANS[0] && (BURST_EN != 0)) || (RAM_LATENCY == 0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = bus.HADDR[BW+IW-1:BW];
          write_d = bus.HWRITE;
          if (fast) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  // Array is deliberately left out of reset; an aborted write never reaches DATA.
  always_ff @(posedge HCLK) begin
    if (state_q == S_DATA && write_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.HWSTRB[b]) mem_q[idx_q][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
      end
    end
  end

  assign bus.HREADOUT = (state_q != S_WAIT);
  assign bus.HRESP    = 1'b0;
  assign bus.HRDATA   = (state_q == S_DATA && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: doc/ahb_wait_ram.md
AHB_WAIT_RAM -- requirements
Module: ahb_wait_ram

Interface
REQ-001 SHALL have parameter AHBW, default 64: bus data width in bits, 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 1024: array depth in AHBW-bit words, power of 2.
REQ-003 SHALL have parameter RAM_LATENCY, default 0: wait states inserted on each NONSEQ beat.
REQ-004 SHALL have parameter BURST_EN, default 1: SEQ beats take zero wait states when 1, RAM_LATENCY when 0.
REQ-005 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-006 HRESETn  input  1  reset, asynchronous, active-low.
REQ-007 HSELRam  input  1  subordinate select.
REQ-008 HADDR  input  32  byte address.
REQ-009 HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-010 HWRITE  input  1  1=write, 0=read.
REQ-011 HREADY  input  1  bus-wide ready; address phase accepted only when high.
REQ-012 HWDATA  input  AHBW  write data, valid in data phase.
REQ-013 HWSTRB  input  AHBW/8  byte write enables, valid in data phase.
REQ-014 HREADOUT  output  1  data phase complete when high.
REQ-015 HRESP  output  1  response; OKAY (0) only.
REQ-016 HRDATA  output  AHBW  read data, valid when HREADOUT high in a read data phase.

Function
REQ-017 Address phase SHALL be accepted on an edge where HSELRam=1, HREADY=1 and HTRANS[1]=1; HWRITE, HTRANS[0] and word index SHALL be registered.
REQ-018 Word index SHALL be HADDR[log2(AHBW/8)+log2(DEPTH)-1 : log2(AHBW/8)]; higher bits ignored, so addresses wrap modulo DEPTH words.
REQ-019 FSM states: IDLE, WAIT, DATA.
REQ-020 IDLE: HREADOUT=1; accepted NONSEQ with RAM_LATENCY>0 -> WAIT, counter loaded with RAM_LATENCY-1; accepted NONSEQ with RAM_LATENCY=0 -> DATA.
REQ-021 Accepted SEQ SHALL behave as NONSEQ when BURST_EN=0 and go directly to DATA when BURST_EN=1.
REQ-022 WAIT: HREADOUT=0; counter decrements each cycle; at counter=0 -> DATA next cycle.
REQ-023 DATA: HREADOUT=1 for exactly one cycle; a new accepted transfer in the same cycle applies REQ-020/021, otherwise -> IDLE.
REQ-024 Transfers with HTRANS IDLE or BUSY, or HSELRam=0, SHALL not change state and SHALL see zero-wait OKAY.
REQ-025 Total data-phase length SHALL be 1+RAM_LATENCY cycles (NONSEQ) and 1 cycle (SEQ, BURST_EN=1).
REQ-026 Write: array bytes with HWSTRB[i]=1 SHALL update on the edge ending DATA; other bytes SHALL be unchanged.
REQ-027 Read: HRDATA SHALL equal the array word at the registered index during DATA; HRDATA SHALL be 0 outside a read DATA cycle.
REQ-028 Write followed back-to-back by read of same word SHALL return the newly written bytes.
REQ-029 HRESP SHALL be 0 in every cycle.
REQ-030 Address phases SHALL not be accepted while HREADOUT=0, as HREADY is low then by protocol; no queuing beyond one pending transfer.

Reset
REQ-031 HRESETn=0 SHALL immediately force state IDLE, counter 0, HREADOUT=1, HRDATA=0, HRESP=0, with no clock.
REQ-032 Reset mid-transfer SHALL abort it; a pending write SHALL not update the array.
REQ-033 Array contents SHALL not be reset.
REQ-034 After HRESETn rises, first accepted transfer SHALL follow REQ-020 timing exactly.

Verification
REQ-035 RAM_LATENCY=0: write 0x1122334455667788 to 0x100 strobe 0xFF, then read 0x100 -> HREADOUT never low, HRDATA=0x1122334455667788.
REQ-036 RAM_LATENCY=3: NONSEQ read -> HREADOUT low exactly 3 cycles, then high 1 cycle with correct data.
REQ-037 RAM_LATENCY=2, BURST_EN=1: INCR4 read burst -> HREADOUT low 2 cycles on beat 1 only; 4 data beats in 7 cycles.
REQ-038 Partial write HWSTRB=0x0F data 0xFFFFFFFFFFFFFFFF over word 0 -> readback 0x00000000FFFFFFFF.
REQ-039 Index wrap: DEPTH=1024, AHBW=64, write 0xA5 to 0x0, read 0x2000 -> 0xA5.
REQ-040 RAM_LATENCY=3, HRESETn low during WAIT of a write -> HREADOUT=1 same cycle, array word unchanged on readback.
